// File: rtl/bus_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_host_arbiter
// Purpose  : Shares one device request port between NrHosts bus hosts.
//            Each cycle one requesting host is selected, and its address phase
//            is forwarded to the device. Granted host IDs are queued in order,
//            so responses are routed back to the host that issued them.
// Options  : BUS_ARB_RR_EN defined   -> round-robin arbitration
//            BUS_ARB_RR_EN undefined -> fixed priority, lowest index wins
// Revision : 1.0 - initial release
// ============================================================================
module bus_host_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  // host side
  input  logic [NrHosts-1:0]                        host_req_i,
  output logic [NrHosts-1:0]                        host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0]                        host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
  output logic [NrHosts-1:0]                        host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
  output logic [NrHosts-1:0]                        host_err_o,
  // device side
  output logic                                      dev_req_o,
  input  logic                                      dev_gnt_i,
  output logic [AddressWidth-1:0]                   dev_addr_o,
  output logic                                      dev_we_o,
  output logic [DataWidth/8-1:0]                    dev_be_o,
  output logic [DataWidth-1:0]                      dev_wdata_o,
  input  logic                                      dev_rvalid_i,
  input  logic [DataWidth-1:0]                      dev_rdata_i,
  input  logic                                      dev_err_i,
  // status
  output logic [$clog2(MaxOutstanding+1)-1:0]       outstanding_o,
  output logic                                      unexpected_rsp_o
);

  // --------------------------------------------------------------------------
  // Derived widths
  // --------------------------------------------------------------------------
  localparam int unsigned c_IdW  = $clog2(NrHosts);
  localparam int unsigned c_CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned c_PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned c_BeW  = DataWidth / 8;

  localparam logic [c_CntW-1:0] c_CntFull = c_CntW'(MaxOutstanding);
  localparam logic [c_PtrW-1:0] c_PtrLast = c_PtrW'(MaxOutstanding - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_IdW-1:0]  id_fifo_q [MaxOutstanding];
  logic [c_PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CntW-1:0] count_q, count_d;
  logic              unexp_q, unexp_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [c_IdW-1:0]  w_sel;
  logic              w_any_req;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [c_IdW-1:0]  w_head;

  // Pointers step modulo MaxOutstanding, so depths that are not powers of two wrap correctly.
  function automatic logic [c_PtrW-1:0] ptr_inc(input logic [c_PtrW-1:0] p);
    if (p == c_PtrLast) begin
      return '0;
    end
    return p + c_PtrW'(1);
  endfunction

  assign w_any_req = |host_req_i;
  assign w_full    = (count_q == c_CntFull);
  assign w_empty   = (count_q == '0);

  // The full check uses the registered count, so a pop in this cycle does not free a slot until the next cycle.
  assign dev_req_o = w_any_req & ~w_full;
  assign w_push    = dev_req_o & dev_gnt_i;
  assign w_pop     = dev_rvalid_i & ~w_empty;
  assign w_head    = id_fifo_q[rd_ptr_q];

`ifdef BUS_ARB_RR_EN
  // --------------------------------------------------------------------------
  // Round-robin selection: search begins at rr_q and wraps around the hosts.
  // --------------------------------------------------------------------------
  logic [c_IdW-1:0] rr_q, rr_d;

  logic [2*NrHosts-1:0] w_req_dbl;
  logic [2*NrHosts-1:0] w_req_shift;
  logic [NrHosts-1:0]   w_req_rot;
  logic [c_IdW:0]       w_off;
  logic [c_IdW:0]       w_sum;

  // Rotate the request vector so bit 0 is the host at rr_q, then take the first set bit.
  always_comb begin
    w_req_dbl   = {host_req_i, host_req_i};
    w_req_shift = w_req_dbl >> rr_q;
    w_req_rot   = w_req_shift[NrHosts-1:0];
    w_off       = '0;
    for (int i = int'(NrHosts) - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_off = (c_IdW+1)'(i);
      end
    end
    w_sum = {1'b0, rr_q} + w_off;
    if (w_sum >= (c_IdW+1)'(NrHosts)) begin
      w_sum = w_sum - (c_IdW+1)'(NrHosts);
    end
    w_sel = w_sum[c_IdW-1:0];
  end

  // After each grant, the host following the winner gets first priority next time.
  always_comb begin
    rr_d = rr_q;
    if (w_push) begin
      if (w_sel == c_IdW'(NrHosts - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = w_sel + c_IdW'(1);
      end
    end
  end

  // The round-robin pointer only moves on cycles that issue a grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // --------------------------------------------------------------------------
  // Fixed priority selection: the lowest-index requester wins.
  // --------------------------------------------------------------------------
  // Scanning from the top down lets the lowest requesting index overwrite w_sel last.
  always_comb begin
    w_sel = '0;
    for (int i = int'(NrHosts) - 1; i >= 0; i--) begin
      if (host_req_i[i]) begin
        w_sel = c_IdW'(i);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Device address phase: forward the selected host's fields, or zero when idle.
  // --------------------------------------------------------------------------
  assign dev_addr_o  = dev_req_o ? host_addr_i[w_sel]  : '0;
  assign dev_we_o    = dev_req_o ? host_we_i[w_sel]    : 1'b0;
  assign dev_be_o    = dev_req_o ? host_be_i[w_sel]    : {c_BeW{1'b0}};
  assign dev_wdata_o = dev_req_o ? host_wdata_i[w_sel] : '0;

  // Grant and response routing: one-hot on the selected host or the FIFO head.
  always_comb begin
    host_gnt_o            = '0;
    host_rvalid_o         = '0;
    host_err_o            = '0;
    host_gnt_o[w_sel]     = w_push;
    host_rvalid_o[w_head] = w_pop;
    host_err_o[w_head]    = w_pop & dev_err_i;
  end

  // Read data is broadcast to all hosts, and each host qualifies it with its own rvalid.
  for (genvar g = 0; g < int'(NrHosts); g++) begin : g_rdata
    assign host_rdata_o[g] = dev_rdata_i;
  end

  // --------------------------------------------------------------------------
  // ID FIFO bookkeeping
  // --------------------------------------------------------------------------
  // Next-state pointers, count and the sticky unexpected-response flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unexp_d  = unexp_q;
    if (w_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (w_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CntW'(1);
      2'b01:   count_d = count_q - c_CntW'(1);
      default: count_d = count_q;
    endcase
    if (dev_rvalid_i && w_empty) begin
      unexp_d = 1'b1;
    end
  end

  // Control registers are cleared by reset, which also flushes any in-flight IDs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      unexp_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      unexp_q  <= unexp_d;
    end
  end

  // Store the granted host ID. The storage needs no reset because the count guards every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      id_fifo_q[wr_ptr_q] <= w_sel;
    end
  end

  assign outstanding_o    = count_q;
  assign unexpected_rsp_o = unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_host_arbiter
// Purpose  : Directed self-checking bench for bus_host_arbiter (2 hosts, depth 2).
//            Expectations follow BUS_ARB_RR_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_host_arbiter;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [1:0]       host_req;
  logic [1:0]       host_gnt;
  logic [1:0][31:0] host_addr;
  logic [1:0]       host_we;
  logic [1:0][3:0]  host_be;
  logic [1:0][31:0] host_wdata;
  logic [1:0]       host_rvalid;
  logic [1:0][31:0] host_rdata;
  logic [1:0]       host_err;
  logic             dev_req;
  logic             dev_gnt;
  logic [31:0]      dev_addr;
  logic             dev_we;
  logic [3:0]       dev_be;
  logic [31:0]      dev_wdata;
  logic             dev_rvalid;
  logic [31:0]      dev_rdata;
  logic             dev_err;
  logic [1:0]       outstanding;
  logic             unexpected;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts(2), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
    .outstanding_o(outstanding), .unexpected_rsp_o(unexpected)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; host_req = '0; host_addr = '0; host_we = '0; host_be = '0;
    host_wdata = '0; dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;
    tick(); tick();
    n_cmp++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    n_cmp++; if (unexpected !== 1'b0) begin n_err++; $display("FAIL reset_unexpected got %b want 0", unexpected); end
    n_cmp++; if ({dev_req, host_gnt, host_rvalid} !== 5'b0) begin n_err++; $display("FAIL reset_idle got %b want 00000", {dev_req, host_gnt, host_rvalid}); end
    n_cmp++; if (dev_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", dev_addr); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    host_req = 2'b01; host_addr[0] = 32'h0000_0100; host_be[0] = 4'hF; host_we[0] = 1'b0;
    dev_gnt = 1'b1;
    #1;
    n_cmp++; if (host_gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt got %b want 01", host_gnt); end
    n_cmp++; if ({dev_req, dev_we, dev_be} !== 6'b10_1111) begin n_err++; $display("FAIL single_ctrl got %b want 101111", {dev_req, dev_we, dev_be}); end
    n_cmp++; if (dev_addr !== 32'h0000_0100) begin n_err++; $display("FAIL single_addr got %h want 00000100", dev_addr); end
    tick();
    host_req = 2'b00;
    n_cmp++; if (outstanding !== 2'd1) begin n_err++; $display("FAIL single_out1 got %0d want 1", outstanding); end
    dev_rvalid = 1'b1; dev_rdata = 32'hDEADBEEF; dev_err = 1'b0;
    #1;
    n_cmp++; if (host_rvalid !== 2'b01) begin n_err++; $display("FAIL single_rvalid got %b want 01", host_rvalid); end
    n_cmp++; if (host_rdata[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata got %h want deadbeef", host_rdata[0]); end
    n_cmp++; if (host_err !== 2'b00) begin n_err++; $display("FAIL single_err got %b want 00", host_err); end
    tick();
    dev_rvalid = 1'b0;
    #1;
    n_cmp++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL single_out0 got %0d want 0", outstanding); end
  endtask

  task automatic test_priority_full();
    logic [1:0]  g1, g2;
    logic [31:0] a1;
`ifdef BUS_ARB_RR_EN
    g1 = 2'b10; g2 = 2'b01; a1 = 32'h0000_0200;
`else
    g1 = 2'b01; g2 = 2'b01; a1 = 32'h0000_0100;
`endif
    host_req = 2'b11; host_addr[1] = 32'h0000_0200; host_we[1] = 1'b1;
    host_be[1] = 4'h3; host_wdata[1] = 32'hCAFE_0001; dev_gnt = 1'b1;
    #1;
    n_cmp++; if (host_gnt !== g1) begin n_err++; $display("FAIL prio_gnt1 got %b want %b", host_gnt, g1); end
    n_cmp++; if (dev_addr !== a1) begin n_err++; $display("FAIL prio_addr1 got %h want %h", dev_addr, a1); end
    tick();
    n_cmp++; if (outstanding !== 2'd1) begin n_err++; $display("FAIL prio_out1 got %0d want 1", outstanding); end
    n_cmp++; if (host_gnt !== g2) begin n_err++; $display("FAIL prio_gnt2 got %b want %b", host_gnt, g2); end
    tick();
    n_cmp++; if (outstanding !== 2'd2) begin n_err++; $display("FAIL prio_out2 got %0d want 2", outstanding); end
    n_cmp++; if ({dev_req, host_gnt} !== 3'b000) begin n_err++; $display("FAIL prio_stall got %b want 000", {dev_req, host_gnt}); end
    n_cmp++; if (dev_addr !== 32'h0) begin n_err++; $display("FAIL prio_idle_addr got %h want 0", dev_addr); end
    tick();
    n_cmp++; if (outstanding !== 2'd2) begin n_err++; $display("FAIL prio_out_hold got %0d want 2", outstanding); end
  endtask

  task automatic test_full_pop();
    logic [1:0] r1, g, r2, r3;
`ifdef BUS_ARB_RR_EN
    r1 = 2'b10; g = 2'b10; r2 = 2'b01; r3 = 2'b10;
`else
    r1 = 2'b01; g = 2'b01; r2 = 2'b01; r3 = 2'b01;
`endif
    dev_rvalid = 1'b1; dev_err = 1'b0;
    #1;
    n_cmp++; if ({dev_req, host_gnt} !== 3'b000) begin n_err++; $display("FAIL fullpop_nogrant got %b want 000", {dev_req, host_gnt}); end
    n_cmp++; if (host_rvalid !== r1) begin n_err++; $display("FAIL fullpop_rvalid got %b want %b", host_rvalid, r1); end
    tick();
    dev_rvalid = 1'b0;
    #1;
    n_cmp++; if (host_gnt !== g) begin n_err++; $display("FAIL fullpop_gnt_next got %b want %b", host_gnt, g); end
    tick();
    n_cmp++; if (outstanding !== 2'd2) begin n_err++; $display("FAIL fullpop_out got %0d want 2", outstanding); end
    host_req = 2'b00; dev_rvalid = 1'b1;
    #1;
    n_cmp++; if (host_rvalid !== r2) begin n_err++; $display("FAIL drain1_rvalid got %b want %b", host_rvalid, r2); end
    tick();
    n_cmp++; if (host_rvalid !== r3) begin n_err++; $display("FAIL drain2_rvalid got %b want %b", host_rvalid, r3); end
    tick();
    dev_rvalid = 1'b0;
    #1;
    n_cmp++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL drain_out got %0d want 0", outstanding); end
  endtask

  task automatic test_ordered_err();
    host_req = 2'b10; dev_gnt = 1'b1;
    #1;
    n_cmp++; if (host_gnt !== 2'b10) begin n_err++; $display("FAIL order_gnt1 got %b want 10", host_gnt); end
    n_cmp++; if ({dev_we, dev_be, dev_wdata} !== {1'b1, 4'h3, 32'hCAFE_0001}) begin n_err++; $display("FAIL order_wfields got %b %h %h want 1 3 cafe0001", dev_we, dev_be, dev_wdata); end
    tick();
    host_req = 2'b01;
    #1;
    n_cmp++; if (host_gnt !== 2'b01) begin n_err++; $display("FAIL order_gnt0 got %b want 01", host_gnt); end
    tick();
    host_req = 2'b00; dev_rvalid = 1'b1; dev_err = 1'b1;
    #1;
    n_cmp++; if ({host_rvalid, host_err} !== 4'b10_10) begin n_err++; $display("FAIL order_rsp1 got %b want 1010", {host_rvalid, host_err}); end
    tick();
    dev_err = 1'b0;
    #1;
    n_cmp++; if ({host_rvalid, host_err} !== 4'b01_00) begin n_err++; $display("FAIL order_rsp0 got %b want 0100", {host_rvalid, host_err}); end
    tick();
    dev_rvalid = 1'b0;
    #1;
    n_cmp++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL order_out got %0d want 0", outstanding); end
  endtask

  task automatic test_back_to_back();
    host_req = 2'b01; dev_gnt = 1'b0;
    #1;
    n_cmp++; if ({dev_req, host_gnt} !== 3'b100) begin n_err++; $display("FAIL b2b_nodevgnt got %b want 100", {dev_req, host_gnt}); end
    tick();
    n_cmp++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL b2b_out_nogrant got %0d want 0", outstanding); end
    dev_gnt = 1'b1;
    tick();
    host_req = 2'b10; dev_rvalid = 1'b1;
    #1;
    n_cmp++; if ({host_gnt, host_rvalid} !== 4'b10_01) begin n_err++; $display("FAIL b2b_pushpop got %b want 1001", {host_gnt, host_rvalid}); end
    tick();
    n_cmp++; if (outstanding !== 2'd1) begin n_err++; $display("FAIL b2b_out_same got %0d want 1", outstanding); end
    host_req = 2'b00;
    #1;
    n_cmp++; if (host_rvalid !== 2'b10) begin n_err++; $display("FAIL b2b_wrap_rvalid got %b want 10", host_rvalid); end
    tick();
    dev_rvalid = 1'b0;
    #1;
    n_cmp++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL b2b_out_end got %0d want 0", outstanding); end
  endtask

  task automatic test_unexpected();
    dev_rvalid = 1'b1;
    #1;
    n_cmp++; if (host_rvalid !== 2'b00) begin n_err++; $display("FAIL unexp_rvalid got %b want 00", host_rvalid); end
    tick();
    dev_rvalid = 1'b0;
    n_cmp++; if (unexpected !== 1'b1) begin n_err++; $display("FAIL unexp_set got %b want 1", unexpected); end
    tick();
    n_cmp++; if (unexpected !== 1'b1) begin n_err++; $display("FAIL unexp_sticky got %b want 1", unexpected); end
    host_req = 2'b01; dev_gnt = 1'b1;
    tick();
    host_req = 2'b00;
    n_cmp++; if (outstanding !== 2'd1) begin n_err++; $display("FAIL unexp_out1 got %0d want 1", outstanding); end
    rst_ni = 1'b0;
    tick();
    n_cmp++; if ({outstanding, unexpected} !== 3'b000) begin n_err++; $display("FAIL midreset_clear got %b want 000", {outstanding, unexpected}); end
    rst_ni = 1'b1; dev_rvalid = 1'b1;
    #1;
    n_cmp++; if (host_rvalid !== 2'b00) begin n_err++; $display("FAIL late_rsp_rvalid got %b want 00", host_rvalid); end
    tick();
    dev_rvalid = 1'b0;
    n_cmp++; if (unexpected !== 1'b1) begin n_err++; $display("FAIL late_rsp_flag got %b want 1", unexpected); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority_full();
    test_full_pop();
    test_ordered_err();
    test_back_to_back();
    test_unexpected();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
